utlb: RTL and testbench
=======================

UTLB -- requirements
Module: utlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 4 (power of two, 2..16): number of micro-TLB entries.
REQ-002 SHALL have parameter ASID_W, default 8: address-space identifier width.
REQ-003 SHALL have ports clk in 1 (the single clock) and rst in 1 (synchronous, active-high reset).
REQ-004 SHALL have ports flush in 1, which invalidates all entries, and asid in ASID_W, the current address-space identifier.
REQ-005 SHALL have ports req_valid in 1, req_vaddr in 32 and req_ready out 1, forming the lookup request handshake.
REQ-006 SHALL have ports resp_valid out 1, resp_paddr out 32, resp_cache out 3, resp_dirty out 1, resp_pvalid out 1 (page V bit) and resp_miss out 1 (main-TLB miss).
REQ-007 SHALL have ports refill_req out 1, refill_vaddr out 32, refill_ack in 1, refill_miss in 1 and refill_entry in tlbEntry_t (vpn2, asid, G, pagemask[15:0], pfn0/1, c0/1, d0/1, v0/1).

Function
REQ-008 SHALL match entry i when it is valid, (vpn2 XOR va[31:13]) AND NOT {3'b0,pagemask} == 0, and (entry asid == asid OR G).
REQ-009 SHALL use va[12+popcount(pagemask)] to select page 1 (when 1) or page 0; legal pagemask values are 0x0000, 0x0003, 0x000F, ... , 0xFFFF.
REQ-010 SHALL form resp_paddr[31:12] = (pfnX[19:0] AND NOT {4'b0,pagemask}) OR (va[31:12] AND {4'b0,pagemask}), with resp_paddr[11:0] = va[11:0].
REQ-011 SHALL use an FSM with states IDLE and REFILL; req_ready SHALL be 1 only in IDLE.
REQ-012 SHALL accept a request in IDLE when req_valid=1; on a hit, it SHALL return resp_valid=1 with the registered result on the next cycle and stay in IDLE (one lookup per cycle).
REQ-013 SHALL, on a miss in IDLE, latch the vaddr, go to REFILL and drive resp_valid=0 on the next cycle.
REQ-014 SHALL, in REFILL, hold refill_req=1 and refill_vaddr equal to the latched vaddr until the cycle in which refill_ack=1.
REQ-015 SHALL, on refill_ack with refill_miss=0, write refill_entry into the victim entry and present the translation with resp_valid=1 on the next cycle, then return to IDLE.
REQ-016 SHALL, on refill_ack with refill_miss=1, install nothing and present resp_valid=1, resp_miss=1 with other response fields 0 on the next cycle, then return to IDLE.
REQ-017 SHALL choose as victim the lowest-index invalid entry, or else the entry at a round-robin pointer that advances by 1 modulo ENTRIES on each replacement of a valid entry.
REQ-018 SHALL make resp_valid a single-cycle pulse with no back-pressure; the other response fields are don't-care when resp_valid=0.
REQ-019 SHALL, on flush, clear all valid bits at the next edge; a flush that coincides with a request forces that request to miss.
REQ-020 SHALL, when flush is asserted during REFILL or in the refill_ack cycle, still return the refill response but not install the entry.
REQ-021 SHALL, if more than one entry matches, take the highest matching index.
REQ-022 SHALL never drive resp_valid and refill_req high in the same cycle.

Reset
REQ-023 SHALL, on rst, go to IDLE, clear all entry valid bits and set the round-robin pointer to 0.
REQ-024 SHALL, during and after rst, drive req_ready=1 and resp_valid, refill_req and resp_miss to 0, with resp_paddr and refill_vaddr equal to 0.
REQ-025 SHALL, when rst is asserted mid-REFILL, abandon the refill (no install, no response) and ignore a later refill_ack.

Structure
REQ-026 SHALL place utlbEntry_t (tlbEntry_t plus valid bit), the state enum and the popcount/select helper in the shared defines package, reusing tlbEntry_t from that package.
REQ-027 SHALL put the per-entry match, page-select and paddr formation in one combinational sub-module, utlb_match, instantiated ENTRIES times.

Verification
REQ-028 SHALL cover a cold miss: request vaddr 0x0040_1234 with asid 5, refill with vpn2=0x00200, pagemask 0, pfn1=0x12345 and refill_ack two cycles later -> refill_req held 2 cycles, then resp_paddr=0x1234_5234; a repeat of the request -> hit with resp_valid on the next cycle and no refill_req.
REQ-029 SHALL cover a 16KB page: pagemask=0x0003, pfn0=0x10000, pfn1=0x20000, vaddr 0x0000_6ABC -> resp_paddr=0x2000_2ABC.
REQ-030 SHALL cover ASID/global behaviour: an entry with asid 3 and G=0 looked up under asid 4 -> miss; the same entry with G=1 -> hit.
REQ-031 SHALL cover a main-TLB miss: refill_ack with refill_miss=1 -> resp_miss=1 pulse and no entry installed (the next identical request misses again).
REQ-032 SHALL cover replacement: fill ENTRIES plus 2 distinct pages -> entries 0 and 1 are evicted in order and the pointer ends at 2.
REQ-033 SHALL cover flush during REFILL, and rst mid-REFILL -> no install; after flush the response is still delivered, after rst no response is given.

Source files
------------

// File: rtl/utlb_pkg.sv
// Shared definitions for the micro-TLB: entry layouts, FSM states and the
// page-select / physical-address helpers used by both lookup and refill paths.
package utlb_pkg;

  // Stored ASID field is wide enough for any supported ASID_W (up to 16 bits).
  localparam int TLB_ASID_W = 16;

  // One main-TLB entry: a pair of even/odd pages sharing a VPN2 tag.
  typedef struct packed {
    logic [18:0]           vpn2;
    logic [TLB_ASID_W-1:0] asid;
    logic                  g;
    logic [15:0]           pagemask;
    logic [19:0]           pfn0;
    logic [19:0]           pfn1;
    logic [2:0]            c0;
    logic [2:0]            c1;
    logic                  d0;
    logic                  d1;
    logic                  v0;
    logic                  v1;
  } tlbEntry_t;

  // Micro-TLB slot: a main-TLB entry plus its local valid bit.
  typedef struct packed {
    tlbEntry_t e;
    logic      valid;
  } utlbEntry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } utlb_state_t;

  // Number of set bits in a page mask (0..16).
  function automatic logic [4:0] popcount16(input logic [15:0] m);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(m[i]);
    end
    return n;
  endfunction

  // Picks the odd page (1) or even page (0): the bit just above the page offset.
  function automatic logic page_select(input logic [15:0] pagemask,
                                       input logic [31:0] va);
    logic [4:0] idx;
    idx = 5'd12 + popcount16(pagemask);
    return va[idx];
  endfunction

  // Masked bits of the frame number come from the virtual address instead.
  function automatic logic [31:0] form_paddr(input logic [19:0] pfn,
                                             input logic [15:0] pagemask,
                                             input logic [31:0] va);
    logic [19:0] mask;
    mask = {4'b0, pagemask};
    return {(pfn & ~mask) | (va[31:12] & mask), va[11:0]};
  endfunction

endpackage

// File: rtl/utlb_match.sv
// Combinational compare/translate for a single micro-TLB slot.
module utlb_match
  import utlb_pkg::*;
#(
  parameter int ASID_W = 8
) (
  input  utlbEntry_t        entry,
  input  logic [31:0]       va,
  input  logic [ASID_W-1:0] asid,
  output logic              hit,
  output logic [31:0]       paddr,
  output logic [2:0]        cache,
  output logic              dirty,
  output logic              pvalid
);

  logic [18:0] vpn_diff;
  logic        asid_ok;
  logic        odd;

  // Tag compare ignores masked VPN bits; global entries ignore the ASID.
  always_comb begin
    vpn_diff = (entry.e.vpn2 ^ va[31:13]) & ~{3'b0, entry.e.pagemask};
    asid_ok  = (entry.e.asid == TLB_ASID_W'(asid)) || entry.e.g;
    hit      = entry.valid && (vpn_diff == '0) && asid_ok;
    odd      = page_select(entry.e.pagemask, va);
    paddr    = form_paddr(odd ? entry.e.pfn1 : entry.e.pfn0, entry.e.pagemask, va);
    cache    = odd ? entry.e.c1 : entry.e.c0;
    dirty    = odd ? entry.e.d1 : entry.e.d0;
    pvalid   = odd ? entry.e.v1 : entry.e.v0;
  end

endmodule

// File: rtl/utlb.sv
// Micro-TLB: fully associative lookup, one request per cycle, refilled from
// the main TLB on a miss with lowest-invalid / round-robin replacement.
module utlb
  import utlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ASID_W-1:0] asid,
  input  logic              req_valid,
  input  logic [31:0]       req_vaddr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_paddr,
  output logic [2:0]        resp_cache,
  output logic              resp_dirty,
  output logic              resp_pvalid,
  output logic              resp_miss,
  output logic              refill_req,
  output logic [31:0]       refill_vaddr,
  input  logic              refill_ack,
  input  logic              refill_miss,
  input  tlbEntry_t         refill_entry
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  utlb_state_t state_q, state_d;

  utlbEntry_t entries_q [ENTRIES];
  logic [PTR_W-1:0] rr_q;
  logic [31:0]      vaddr_q;
  logic             flush_pend_q;

  logic             resp_valid_q;
  logic             resp_miss_q;
  logic [31:0]      resp_paddr_q;
  logic [2:0]       resp_cache_q;
  logic             resp_dirty_q;
  logic             resp_pvalid_q;

  logic [ENTRIES-1:0] hit_vec;
  logic [31:0]        m_paddr  [ENTRIES];
  logic [2:0]         m_cache  [ENTRIES];
  logic               m_dirty  [ENTRIES];
  logic               m_pvalid [ENTRIES];

  logic        lk_hit;
  logic [31:0] lk_paddr;
  logic [2:0]  lk_cache;
  logic        lk_dirty;
  logic        lk_pvalid;

  logic [PTR_W-1:0] victim;
  logic             victim_free;

  logic        rf_odd;
  logic [31:0] rf_paddr;
  logic [2:0]  rf_cache;
  logic        rf_dirty;
  logic        rf_pvalid;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_match
    utlb_match #(
      .ASID_W(ASID_W)
    ) u_match (
      .entry (entries_q[i]),
      .va    (req_vaddr),
      .asid  (asid),
      .hit   (hit_vec[i]),
      .paddr (m_paddr[i]),
      .cache (m_cache[i]),
      .dirty (m_dirty[i]),
      .pvalid(m_pvalid[i])
    );
  end

  // Merge per-slot results; scanning upward lets the highest matching index win.
  always_comb begin
    lk_hit    = 1'b0;
    lk_paddr  = '0;
    lk_cache  = '0;
    lk_dirty  = 1'b0;
    lk_pvalid = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit_vec[i]) begin
        lk_hit    = 1'b1;
        lk_paddr  = m_paddr[i];
        lk_cache  = m_cache[i];
        lk_dirty  = m_dirty[i];
        lk_pvalid = m_pvalid[i];
      end
    end
  end

  // Victim is the lowest free slot, otherwise the round-robin slot.
  always_comb begin
    victim      = rr_q;
    victim_free = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        victim      = PTR_W'(i);
        victim_free = 1'b1;
      end
    end
  end

  // Translation of the latched miss address through the incoming refill entry.
  always_comb begin
    rf_odd    = page_select(refill_entry.pagemask, vaddr_q);
    rf_paddr  = form_paddr(rf_odd ? refill_entry.pfn1 : refill_entry.pfn0,
                           refill_entry.pagemask, vaddr_q);
    rf_cache  = rf_odd ? refill_entry.c1 : refill_entry.c0;
    rf_dirty  = rf_odd ? refill_entry.d1 : refill_entry.d0;
    rf_pvalid = rf_odd ? refill_entry.v1 : refill_entry.v0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a miss (or a flush-forced miss) enters REFILL until the ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid && !(lk_hit && !flush)) state_d = REFILL;
      REFILL:  if (refill_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; reset forces the idle/quiet values immediately.
  always_comb begin
    req_ready    = rst || (state_q == IDLE);
    refill_req   = !rst && (state_q == REFILL);
    refill_vaddr = rst ? '0 : vaddr_q;
    resp_valid   = !rst && resp_valid_q;
    resp_miss    = !rst && resp_miss_q;
    resp_paddr   = rst ? '0 : resp_paddr_q;
    resp_cache   = rst ? '0 : resp_cache_q;
    resp_dirty   = !rst && resp_dirty_q;
    resp_pvalid  = !rst && resp_pvalid_q;
  end

  // Entry array, replacement pointer, miss address and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
      end
      rr_q          <= '0;
      vaddr_q       <= '0;
      flush_pend_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_miss_q   <= 1'b0;
      resp_paddr_q  <= '0;
      resp_cache_q  <= '0;
      resp_dirty_q  <= 1'b0;
      resp_pvalid_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_miss_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          flush_pend_q <= 1'b0;
          if (req_valid) begin
            if (lk_hit && !flush) begin
              resp_valid_q  <= 1'b1;
              resp_paddr_q  <= lk_paddr;
              resp_cache_q  <= lk_cache;
              resp_dirty_q  <= lk_dirty;
              resp_pvalid_q <= lk_pvalid;
            end else begin
              vaddr_q <= req_vaddr;
            end
          end
        end
        REFILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (refill_ack) begin
            resp_valid_q <= 1'b1;
            if (refill_miss) begin
              resp_miss_q   <= 1'b1;
              resp_paddr_q  <= '0;
              resp_cache_q  <= '0;
              resp_dirty_q  <= 1'b0;
              resp_pvalid_q <= 1'b0;
            end else begin
              resp_paddr_q  <= rf_paddr;
              resp_cache_q  <= rf_cache;
              resp_dirty_q  <= rf_dirty;
              resp_pvalid_q <= rf_pvalid;
              if (!flush && !flush_pend_q) begin
                entries_q[victim] <= '{e: refill_entry, valid: 1'b1};
                if (!victim_free) rr_q <= rr_q + PTR_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          entries_q[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_utlb.sv
// Directed bench for the micro-TLB: cold miss, hits, large pages, ASID/global,
// main-TLB miss, replacement order, flush and reset during refill.
module tb_utlb;
  import utlb_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  asid;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic [2:0]  resp_cache;
  logic        resp_dirty;
  logic        resp_pvalid;
  logic        resp_miss;
  logic        refill_req;
  logic [31:0] refill_vaddr;
  logic        refill_ack;
  logic        refill_miss;
  tlbEntry_t   refill_entry;

  int n_checks;
  int n_fail;

  utlb #(
    .ENTRIES(4),
    .ASID_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .asid        (asid),
    .req_valid   (req_valid),
    .req_vaddr   (req_vaddr),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_paddr  (resp_paddr),
    .resp_cache  (resp_cache),
    .resp_dirty  (resp_dirty),
    .resp_pvalid (resp_pvalid),
    .resp_miss   (resp_miss),
    .refill_req  (refill_req),
    .refill_vaddr(refill_vaddr),
    .refill_ack  (refill_ack),
    .refill_miss (refill_miss),
    .refill_entry(refill_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Entry with even page cache 2 / clean, odd page cache 3 / dirty, both valid.
  function automatic tlbEntry_t mk_entry(input logic [18:0] vpn2, input logic [15:0] easid,
                                         input logic g, input logic [15:0] pm,
                                         input logic [19:0] p0, input logic [19:0] p1);
    tlbEntry_t t;
    t          = '0;
    t.vpn2     = vpn2;
    t.asid     = easid;
    t.g        = g;
    t.pagemask = pm;
    t.pfn0     = p0;
    t.pfn1     = p1;
    t.c0       = 3'd2;
    t.c1       = 3'd3;
    t.d0       = 1'b0;
    t.d1       = 1'b1;
    t.v0       = 1'b1;
    t.v1       = 1'b1;
    return t;
  endfunction

  // Request expected to hit: response on the next cycle, no refill.
  task automatic lookup_hit(input string tag, input logic [31:0] va,
                            input logic [31:0] exp_pa, input logic [2:0] exp_c);
    check_output({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_vaddr = va;
    @(negedge clk);
    req_valid = 1'b0;
    check_output({tag, "/resp_valid"}, 32'(resp_valid), 32'd1);
    check_output({tag, "/refill_req"}, 32'(refill_req), 32'd0);
    check_output({tag, "/resp_miss"},  32'(resp_miss), 32'd0);
    check_output({tag, "/paddr"},      resp_paddr, exp_pa);
    check_output({tag, "/cache"},      32'(resp_cache), 32'(exp_c));
  endtask

  // Request expected to miss, then refilled after ack_delay REFILL cycles.
  // flush_cycle: -1 none, 0 together with the request, k in REFILL cycle k.
  task automatic refill_txn(input string tag, input logic [31:0] va, input tlbEntry_t ent,
                            input int ack_delay, input logic main_miss, input int flush_cycle,
                            input logic [31:0] exp_pa, input logic [2:0] exp_c,
                            input logic exp_d);
    check_output({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_vaddr = va;
    flush     = (flush_cycle == 0);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = (flush_cycle == 1);
    check_output({tag, "/miss_resp_valid"}, 32'(resp_valid), 32'd0);
    check_output({tag, "/refill_req"},      32'(refill_req), 32'd1);
    check_output({tag, "/refill_vaddr"},    refill_vaddr, va);
    check_output({tag, "/busy_ready"},      32'(req_ready), 32'd0);
    for (int k = 2; k <= ack_delay; k++) begin
      @(negedge clk);
      flush = (flush_cycle == k);
      check_output({tag, "/refill_req_held"}, 32'(refill_req), 32'd1);
    end
    refill_ack   = 1'b1;
    refill_miss  = main_miss;
    refill_entry = ent;
    @(negedge clk);
    refill_ack  = 1'b0;
    refill_miss = 1'b0;
    flush       = 1'b0;
    check_output({tag, "/resp_valid"},    32'(resp_valid), 32'd1);
    check_output({tag, "/refill_req_lo"}, 32'(refill_req), 32'd0);
    check_output({tag, "/resp_miss"},     32'(resp_miss), 32'(main_miss));
    check_output({tag, "/paddr"},         resp_paddr, exp_pa);
    check_output({tag, "/cache"},         32'(resp_cache), 32'(exp_c));
    check_output({tag, "/dirty"},         32'(resp_dirty), 32'(exp_d));
    check_output({tag, "/pvalid"},        32'(resp_pvalid), 32'(!main_miss));
  endtask

  initial begin
    logic [31:0] va;
    logic [31:0] pa;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    asid         = 8'd5;
    req_valid    = 1'b0;
    req_vaddr    = '0;
    refill_ack   = 1'b0;
    refill_miss  = 1'b0;
    refill_entry = '0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check_output("rst/req_ready",    32'(req_ready), 32'd1);
    check_output("rst/resp_valid",   32'(resp_valid), 32'd0);
    check_output("rst/refill_req",   32'(refill_req), 32'd0);
    check_output("rst/resp_miss",    32'(resp_miss), 32'd0);
    check_output("rst/resp_paddr",   resp_paddr, 32'd0);
    check_output("rst/refill_vaddr", refill_vaddr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("post_rst/req_ready",  32'(req_ready), 32'd1);
    check_output("post_rst/resp_valid", 32'(resp_valid), 32'd0);

    // Cold miss, ack two cycles later, odd 4KB page -> slot 0.
    refill_txn("cold", 32'h0040_1234, mk_entry(19'h00200, 16'd5, 1'b0, 16'h0000, 20'h0AAAA, 20'h12345),
               2, 1'b0, -1, 32'h1234_5234, 3'd3, 1'b1);
    @(negedge clk);
    check_output("cold/pulse_end", 32'(resp_valid), 32'd0);
    lookup_hit("cold_hit", 32'h0040_1234, 32'h1234_5234, 3'd3);
    lookup_hit("cold_even", 32'h0040_0ABC, 32'h0AAA_AABC, 3'd2);

    // 16KB page -> slot 1.
    refill_txn("p16k", 32'h0000_6ABC, mk_entry(19'h0, 16'd5, 1'b0, 16'h0003, 20'h10000, 20'h20000),
               1, 1'b0, -1, 32'h2000_2ABC, 3'd3, 1'b1);
    lookup_hit("p16k_even", 32'h0000_2ABC, 32'h1000_2ABC, 3'd2);

    // ASID mismatch misses; global entry hits; with both matching, slot 3 wins.
    asid = 8'd4;
    refill_txn("asid_miss", 32'h0040_1234, mk_entry(19'h0, 16'd0, 1'b0, 16'h0, 20'h0, 20'h0),
               1, 1'b1, -1, 32'h0, 3'd0, 1'b0);
    refill_txn("asid3_fill", 32'h0060_0010, mk_entry(19'h00300, 16'd3, 1'b0, 16'h0, 20'h33333, 20'h0),
               1, 1'b0, -1, 32'h3333_3010, 3'd2, 1'b0);
    refill_txn("glob_fill", 32'h0060_0010, mk_entry(19'h00300, 16'd3, 1'b1, 16'h0, 20'h44444, 20'h0),
               1, 1'b0, -1, 32'h4444_4010, 3'd2, 1'b0);
    lookup_hit("glob_hit", 32'h0060_0010, 32'h4444_4010, 3'd2);
    asid = 8'd3;
    lookup_hit("multi_hit", 32'h0060_0010, 32'h4444_4010, 3'd2);

    // Main-TLB miss installs nothing.
    asid = 8'd5;
    refill_txn("main_miss", 32'h0080_0000, mk_entry(19'h00400, 16'd5, 1'b0, 16'h0, 20'h77777, 20'h0),
               1, 1'b1, -1, 32'h0, 3'd0, 1'b0);
    refill_txn("main_miss_again", 32'h0080_0000, mk_entry(19'h00400, 16'd5, 1'b0, 16'h0, 20'h77777, 20'h0),
               1, 1'b1, -1, 32'h0, 3'd0, 1'b0);

    // Flush during REFILL: response still delivered, nothing installed.
    refill_txn("flush_refill", 32'h00A0_0000, mk_entry(19'h00500, 16'd5, 1'b0, 16'h0, 20'h55555, 20'h66666),
               2, 1'b0, 1, 32'h5555_5000, 3'd2, 1'b0);
    refill_txn("flush_not_installed", 32'h00A0_0000, '0, 1, 1'b1, -1, 32'h0, 3'd0, 1'b0);
    refill_txn("flush_cleared_old", 32'h0040_1234, '0, 1, 1'b1, -1, 32'h0, 3'd0, 1'b0);

    // Replacement: six pages into four empty slots evicts slots 0 then 1.
    for (int k = 0; k < 6; k++) begin
      va = 32'((32'h1000 + k) << 13);
      pa = 32'((32'h60000 + k) << 12);
      refill_txn("fill", va, mk_entry(19'(32'h1000 + k), 16'd5, 1'b0, 16'h0, 20'(32'h60000 + k), 20'h0),
                 1, 1'b0, -1, pa, 3'd2, 1'b0);
    end
    for (int k = 2; k < 6; k++) begin
      lookup_hit("kept", 32'((32'h1000 + k) << 13), 32'((32'h60000 + k) << 12), 3'd2);
    end
    refill_txn("evicted0", 32'h0200_0000, mk_entry(19'h01000, 16'd5, 1'b0, 16'h0, 20'h60000, 20'h0),
               1, 1'b0, -1, 32'h6000_0000, 3'd2, 1'b0);
    lookup_hit("refilled0", 32'h0200_0000, 32'h6000_0000, 3'd2);
    refill_txn("ptr_was_2", 32'h0200_4000, '0, 1, 1'b1, -1, 32'h0, 3'd0, 1'b0);
    lookup_hit("slot3_kept", 32'h0200_6000, 32'h6000_3000, 3'd2);
    refill_txn("evicted1", 32'h0200_2000, '0, 1, 1'b1, -1, 32'h0, 3'd0, 1'b0);

    // Flush together with a request forces that request to miss.
    refill_txn("flush_req", 32'h0200_6000, '0, 1, 1'b1, 0, 32'h0, 3'd0, 1'b0);
    refill_txn("flush_req_after", 32'h0200_6000, '0, 1, 1'b1, -1, 32'h0, 3'd0, 1'b0);

    // Reset mid-REFILL: refill abandoned, later ack ignored, nothing installed.
    req_valid = 1'b1;
    req_vaddr = 32'h00C0_0000;
    @(negedge clk);
    req_valid = 1'b0;
    check_output("rst_mid/refill_req", 32'(refill_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_mid/hold_refill_req", 32'(refill_req), 32'd0);
    check_output("rst_mid/hold_ready",      32'(req_ready), 32'd1);
    check_output("rst_mid/hold_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    refill_ack   = 1'b1;
    refill_entry = mk_entry(19'h00600, 16'd5, 1'b0, 16'h0, 20'h88888, 20'h0);
    @(negedge clk);
    refill_ack = 1'b0;
    check_output("rst_mid/late_ack_resp_valid", 32'(resp_valid), 32'd0);
    check_output("rst_mid/late_ack_refill_req", 32'(refill_req), 32'd0);
    check_output("rst_mid/refill_vaddr",        refill_vaddr, 32'd0);
    refill_txn("rst_mid_not_installed", 32'h00C0_0000, '0, 1, 1'b1, -1, 32'h0, 3'd0, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
